stopwatch_bcd: RTL
==================

// Module: stopwatch_bcd
// PURPOSE
//  - Stopwatch core downstream of the divide-by-100 clock divider.
//  - Samples the divider output as a level, synchronous to clk_ref, and counts its rising edges.
//  - Counts into a 4-digit BCD time value SS.CC: one LSB (centisecond) per detected edge.
//  - Start/stop and clear buttons drive a 3-state control FSM.
//  - Outputs feed the 7-segment scan driver.
// PARAMETERS
//  SEC_TENS_MAX   5   highest value of sec_tens digit before wrap (59.99 -> 00.00)
//  EDGE_FALL      0   0: count rising edges of tick_in; 1: count falling edges
// PORTS
//  clk_ref      in   1  system clock; single clock domain
//  rst          in   1  synchronous, active-low reset
//  tick_in      in   1  divided-clock level from freq divider, synchronous to clk_ref
//  btn_ss       in   1  start/stop button level (already debounced), active-high
//  btn_clr      in   1  clear button level (already debounced), active-high
//  cs_ones      out  4  BCD centiseconds units, 0..9
//  cs_tens      out  4  BCD centiseconds tens, 0..9
//  sec_ones     out  4  BCD seconds units, 0..9
//  sec_tens     out  4  BCD seconds tens, 0..SEC_TENS_MAX
//  running      out  1  1 while FSM in RUN
//  wrap         out  1  1-cycle pulse on the cycle after 59.99 -> 00.00 rollover
// BEHAVIOUR
//  Reset (rst==0 at posedge clk_ref):
//   - all digits 0; running=0; wrap=0; FSM=IDLE; tick_d=0.
//   - btn_ss_d=1 and btn_clr_d=1, so a button held through reset gives no press.
//  Edge detect (registered previous value, one flop each):
//   - tick_edge = tick_in & ~tick_d (EDGE_FALL=0) or ~tick_in & tick_d (EDGE_FALL=1).
//   - ss_press = btn_ss & ~btn_ss_d; clr_press = btn_clr & ~btn_clr_d.
//   - A held button gives exactly one press.
//  FSM states IDLE(00) RUN(01) PAUSE(10); 11 is illegal -> IDLE on next clock:
//   - IDLE : ss_press -> RUN; clr_press is a no-op (digits already 0).
//   - RUN  : ss_press -> PAUSE; clr_press ignored.
//   - PAUSE: clr_press -> IDLE and zero all digits (clear has priority over ss_press);
//            else ss_press -> RUN.
//  Counting:
//   - Digits advance only when current state==RUN and tick_edge==1.
//   - New value is visible the cycle after the edge is seen (latency 1 from tick_in change).
//   - Cascade: cs_ones 9->0 carries to cs_tens; cs_tens 9->0 carries to sec_ones;
//     sec_ones 9->0 carries to sec_tens; sec_tens SEC_TENS_MAX->0 = full wrap.
//   - Full wrap: all digits 0 and wrap=1 for exactly one cycle.
//  Simultaneous events:
//   - Edge in the same cycle as ss_press in RUN: the edge is counted, then PAUSE.
//   - Edge in the same cycle as the IDLE/PAUSE->RUN transition: not counted.
//  running is registered: equals (state==RUN), updates with the state.
//  Reset mid-count: digits return to 0 on that clock edge; no wrap pulse.
//  Digits never hold non-BCD values; increment is the only arithmetic (4-bit, no binary overflow).
// STRUCTURE
//  Shared package/header:
//   - state encodings ST_IDLE, ST_RUN, ST_PAUSE.
//   - BCD_W=4, BCD_MAX=4'd9, default SEC_TENS_MAX.
//  Sub-module bcd_digit_cnt (param MAX):
//   - ports clk_ref, rst, clr, inc, q[3:0], carry.
//   - carry = inc & (q==MAX), combinational.
//   - Instantiate 4x, chained inc <- carry of the lower digit.
//  Top: edge-detect flops, FSM, wrap register, digit chain.
// TESTING
//  1 Reset with btn_ss held high, release rst -> running stays 0, no state change.
//  2 Press btn_ss, drive 100 tick_in rising edges -> running=1, digits read 01.00.
//  3 Preload 59.99 via 1 tick edge short of wrap, one more edge -> 00.00, wrap=1 for 1 cycle only.
//  4 RUN at 00.05: ss_press coincident with tick edge -> 00.06, running=0;
//    further edges leave 00.06.
//  5 PAUSE at 12.34: btn_ss and btn_clr rise same cycle -> IDLE, 00.00, running=0.
//  6 RUN at 03.21, assert rst for 1 cycle -> all digits 0, running=0, wrap=0;
//    clr_press in RUN -> no effect.

Source files
------------

// File: rtl/stopwatch_bcd_pkg.sv
// stopwatch_bcd_pkg: shared state encodings and BCD constants for the stopwatch
package stopwatch_bcd_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;
  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int unsigned SEC_TENS_MAX_DEF = 5;
endpackage

// File: rtl/stopwatch_bcd_if.sv
// stopwatch_bcd_if: tick/button inputs and BCD display outputs of the stopwatch
interface stopwatch_bcd_if;
  import stopwatch_bcd_pkg::*;
  logic tick_in;
  logic btn_ss;
  logic btn_clr;
  logic [BCD_W-1:0] cs_ones;
  logic [BCD_W-1:0] cs_tens;
  logic [BCD_W-1:0] sec_ones;
  logic [BCD_W-1:0] sec_tens;
  logic running;
  logic wrap;
  modport master (
    output tick_in, btn_ss, btn_clr,
    input  cs_ones, cs_tens, sec_ones, sec_tens, running, wrap
  );
  modport slave (
    input  tick_in, btn_ss, btn_clr,
    output cs_ones, cs_tens, sec_ones, sec_tens, running, wrap
  );
endinterface

// File: rtl/stopwatch_bcd_digit_cnt.sv
// bcd_digit_cnt: one BCD digit counting 0..MAX with combinational carry-out
module bcd_digit_cnt import stopwatch_bcd_pkg::*; #(
  parameter logic [BCD_W-1:0] MAX = BCD_MAX
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);
  assign carry = inc & (q == MAX);
  always_ff @(posedge clk_ref)
    if (!rst || clr) q <= '0;
    else if (inc) q <= (q == MAX) ? '0 : q + 4'd1;
endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: start/stop/clear stopwatch counting SS.CC in BCD from divided-clock edges
module stopwatch_bcd import stopwatch_bcd_pkg::*; #(
  parameter int unsigned SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter bit          EDGE_FALL    = 1'b0
) (
  input  logic           clk_ref,
  input  logic           rst,
  stopwatch_bcd_if.slave sw
);
  state_t state, nxt;
  logic tick_d, btn_ss_d, btn_clr_d;
  logic tick_edge, ss_press, clr_press, cnt, clr;
  logic [3:0] c;
  assign tick_edge = EDGE_FALL ? (~sw.tick_in & tick_d) : (sw.tick_in & ~tick_d);
  assign ss_press  = sw.btn_ss & ~btn_ss_d;
  assign clr_press = sw.btn_clr & ~btn_clr_d;
  assign cnt       = (state == ST_RUN) & tick_edge;
  assign clr       = (state == ST_PAUSE) & clr_press;
  always_comb
    nxt = state == ST_IDLE  ? (ss_press ? ST_RUN : ST_IDLE) :
          state == ST_RUN   ? (ss_press ? ST_PAUSE : ST_RUN) :
          state == ST_PAUSE ? (clr_press ? ST_IDLE : ss_press ? ST_RUN : ST_PAUSE) :
                              ST_IDLE;
  // Button history resets high so a button held through reset is not a press
  always_ff @(posedge clk_ref)
    if (!rst) begin
      state      <= ST_IDLE;
      sw.running <= 1'b0;
      sw.wrap    <= 1'b0;
      tick_d     <= 1'b0;
      btn_ss_d   <= 1'b1;
      btn_clr_d  <= 1'b1;
    end else begin
      state      <= nxt;
      sw.running <= nxt == ST_RUN;
      sw.wrap    <= c[3];
      tick_d     <= sw.tick_in;
      btn_ss_d   <= sw.btn_ss;
      btn_clr_d  <= sw.btn_clr;
    end
  bcd_digit_cnt #(.MAX(BCD_MAX)) u_cs_ones (
    .clk_ref(clk_ref), .rst(rst), .clr(clr), .inc(cnt),  .q(sw.cs_ones),  .carry(c[0])
  );
  bcd_digit_cnt #(.MAX(BCD_MAX)) u_cs_tens (
    .clk_ref(clk_ref), .rst(rst), .clr(clr), .inc(c[0]), .q(sw.cs_tens),  .carry(c[1])
  );
  bcd_digit_cnt #(.MAX(BCD_MAX)) u_sec_ones (
    .clk_ref(clk_ref), .rst(rst), .clr(clr), .inc(c[1]), .q(sw.sec_ones), .carry(c[2])
  );
  bcd_digit_cnt #(.MAX(BCD_W'(SEC_TENS_MAX))) u_sec_tens (
    .clk_ref(clk_ref), .rst(rst), .clr(clr), .inc(c[2]), .q(sw.sec_tens), .carry(c[3])
  );
endmodule
